// File: rtl/timer_pkg.sv
// Shared widths, radices and preset clamping for the mm:ss BCD timer.
// Build option: define TIMER_RELOAD_EN to auto-reload the preset at terminal.
package timer_pkg;
    localparam int BCD_W      = 4;
    localparam int SEC_HI_W   = 3;
    localparam int BCD_MAX    = 9;
    localparam int SEC_HI_MAX = 5;

    typedef struct packed {
        logic [BCD_W-1:0]    min_hi;
        logic [BCD_W-1:0]    min_lo;
        logic [SEC_HI_W-1:0] sec_hi;
        logic [BCD_W-1:0]    sec_lo;
    } mmss_t;

    function automatic mmss_t clamp_preset(input mmss_t p);
        mmss_t c;
        c.min_hi = (p.min_hi > BCD_W'(BCD_MAX)) ? BCD_W'(BCD_MAX) : p.min_hi;
        c.min_lo = (p.min_lo > BCD_W'(BCD_MAX)) ? BCD_W'(BCD_MAX) : p.min_lo;
        c.sec_hi = (p.sec_hi > SEC_HI_W'(SEC_HI_MAX)) ? SEC_HI_W'(SEC_HI_MAX) : p.sec_hi;
        c.sec_lo = (p.sec_lo > BCD_W'(BCD_MAX)) ? BCD_W'(BCD_MAX) : p.sec_lo;
        return c;
    endfunction
endpackage

// File: rtl/bcd_timer_if.sv
// Control, preset and display signals of the BCD timer.
interface bcd_timer_if;
    import timer_pkg::*;

    logic                enabled;
    logic                paused;
    logic                count_up;
    logic [BCD_W-1:0]    pre_min_hi;
    logic [BCD_W-1:0]    pre_min_lo;
    logic [SEC_HI_W-1:0] pre_sec_hi;
    logic [BCD_W-1:0]    pre_sec_lo;
    logic [BCD_W-1:0]    min_hi;
    logic [BCD_W-1:0]    min_lo;
    logic [SEC_HI_W-1:0] sec_hi;
    logic [BCD_W-1:0]    sec_lo;
    logic                tick;
    logic                done;
    logic                running;

    modport master (
        output enabled, paused, count_up, pre_min_hi, pre_min_lo, pre_sec_hi, pre_sec_lo,
        input  min_hi, min_lo, sec_hi, sec_lo, tick, done, running
    );
    modport slave (
        input  enabled, paused, count_up, pre_min_hi, pre_min_lo, pre_sec_hi, pre_sec_lo,
        output min_hi, min_lo, sec_hi, sec_lo, tick, done, running
    );
endinterface

// File: rtl/bcd_timer_digit.sv
// One mod-(MAX+1) up/down digit. load selects the preset as the base value
// before stepping, so a digit can load and step on the same edge.
module bcd_digit #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         co
);
    logic [W-1:0] value_q, value_d, src;
    logic         at_edge;

    always_comb begin
        src     = load ? load_val : value_q;
        at_edge = dir ? (src == W'(MAX)) : (src == '0);
        co      = step & at_edge;
        value_d = src;
        if (step) begin
            if (dir) value_d = at_edge ? '0 : src + 1'b1;
            else     value_d = at_edge ? W'(MAX) : src - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value = value_q;
endmodule

// File: rtl/bcd_timer.sv
// mm:ss BCD up/down timer with prescaler, pause, clamped preset and done flag.
// Build option: TIMER_RELOAD_EN turns done into a pulse and reloads the preset.
module bcd_timer
    import timer_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int MAX_MIN = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    bcd_timer_if.slave tif
);
    localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam mmss_t TERM_UP = {BCD_W'(MAX_MIN / 10), BCD_W'(MAX_MIN % 10),
                                 SEC_HI_W'(SEC_HI_MAX), BCD_W'(BCD_MAX)};
    localparam mmss_t NEAR_UP = {BCD_W'(MAX_MIN / 10), BCD_W'(MAX_MIN % 10),
                                 SEC_HI_W'(SEC_HI_MAX), BCD_W'(BCD_MAX - 1)};
    localparam mmss_t NEAR_DN = mmss_t'(1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d, done_q, done_d, run_q, run_d, en_q, en_d;
    logic          load, step, at_term, near_term;
    logic          co_sl, co_sh, co_ml, co_mh_unused;
    mmss_t         pre_c, cur, base;

    // en_q low means the digits do not yet hold a valid preset (idle or just out
    // of reset), so the first running edge works from the preset itself.
    always_comb begin
        pre_c     = clamp_preset({tif.pre_min_hi, tif.pre_min_lo, tif.pre_sec_hi, tif.pre_sec_lo});
        base      = en_q ? cur : pre_c;
        at_term   = tif.count_up ? (base == TERM_UP) : (base == '0);
        near_term = tif.count_up ? (base == NEAR_UP) : (base == NEAR_DN);
        en_d      = tif.enabled;
        presc_d   = presc_q;
        tick_d    = 1'b0;
        done_d    = done_q;
        load      = ~en_q;
        step      = 1'b0;
        if (!tif.enabled) begin
            presc_d = '0;
            done_d  = 1'b0;
            load    = 1'b1;
        end
`ifdef TIMER_RELOAD_EN
        else begin
            done_d = 1'b0;
            if (at_term) begin
                load   = 1'b1;
                done_d = 1'b1;
            end else if (!tif.paused) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (near_term) begin
                        load   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        end
        run_d = tif.enabled & ~tif.paused;
`else
        else if (!done_q) begin
            if (at_term) begin
                done_d = 1'b1;
            end else if (!tif.paused) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    step    = 1'b1;
                    done_d  = near_term;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        end
        run_d = tif.enabled & ~tif.paused & ~done_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            run_q   <= run_d;
            en_q    <= en_d;
        end
    end

    bcd_digit #(.W(BCD_W), .MAX(BCD_MAX)) u_sec_lo (
        .clk(clk), .rst_n(rst_n), .step(step), .dir(tif.count_up), .load(load),
        .load_val(pre_c.sec_lo), .value(cur.sec_lo), .co(co_sl));
    bcd_digit #(.W(SEC_HI_W), .MAX(SEC_HI_MAX)) u_sec_hi (
        .clk(clk), .rst_n(rst_n), .step(co_sl), .dir(tif.count_up), .load(load),
        .load_val(pre_c.sec_hi), .value(cur.sec_hi), .co(co_sh));
    bcd_digit #(.W(BCD_W), .MAX(BCD_MAX)) u_min_lo (
        .clk(clk), .rst_n(rst_n), .step(co_sh), .dir(tif.count_up), .load(load),
        .load_val(pre_c.min_lo), .value(cur.min_lo), .co(co_ml));
    bcd_digit #(.W(BCD_W), .MAX(BCD_MAX)) u_min_hi (
        .clk(clk), .rst_n(rst_n), .step(co_ml), .dir(tif.count_up), .load(load),
        .load_val(pre_c.min_hi), .value(cur.min_hi), .co(co_mh_unused));

    assign tif.min_hi  = cur.min_hi;
    assign tif.min_lo  = cur.min_lo;
    assign tif.sec_hi  = cur.sec_hi;
    assign tif.sec_lo  = cur.sec_lo;
    assign tif.tick    = tick_q;
    assign tif.done    = done_q;
    assign tif.running = run_q;
endmodule

// File: tb/tb_bcd_timer.sv
// Directed scoreboard bench for bcd_timer: three instances at CLK_DIV 1, 2, 3.
module tb_bcd_timer;
    import timer_pkg::*;

`ifdef TIMER_RELOAD_EN
    localparam logic RELOAD = 1'b1;
`else
    localparam logic RELOAD = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [14:0] dig;
        logic        tick;
        logic        done;
        logic        run;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bcd_timer_if if1 ();
    bcd_timer_if if2 ();
    bcd_timer_if if3 ();

    bcd_timer #(.CLK_DIV(1), .MAX_MIN(1)) u1 (.clk(clk), .rst_n(rst_n), .tif(if1));
    bcd_timer #(.CLK_DIV(2), .MAX_MIN(99)) u2 (.clk(clk), .rst_n(rst_n), .tif(if2));
    bcd_timer #(.CLK_DIV(3), .MAX_MIN(99)) u3 (.clk(clk), .rst_n(rst_n), .tif(if3));

    function automatic logic [14:0] mmss(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic push(input string tag, input logic [14:0] dig, input logic tk,
                        input logic dn, input logic rn);
        exp_t e;
        e.tag = tag; e.dig = dig; e.tick = tk; e.done = dn; e.run = rn;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [14:0] dig, input logic tk, input logic dn, input logic rn);
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL sb_empty: observed %h with no expectation queued", dig);
            return;
        end
        e = sb.pop_front();
        total++;
        assert (dig === e.dig) else begin
            bad++; $error("FAIL %s digits: got %h want %h", e.tag, dig, e.dig);
        end
        total++;
        assert (tk === e.tick) else begin
            bad++; $error("FAIL %s tick: got %b want %b", e.tag, tk, e.tick);
        end
        total++;
        assert (dn === e.done) else begin
            bad++; $error("FAIL %s done: got %b want %b", e.tag, dn, e.done);
        end
        total++;
        assert (rn === e.run) else begin
            bad++; $error("FAIL %s running: got %b want %b", e.tag, rn, e.run);
        end
    endtask

    task automatic chk1();
        chk({if1.min_hi, if1.min_lo, if1.sec_hi, if1.sec_lo}, if1.tick, if1.done, if1.running);
    endtask
    task automatic chk2();
        chk({if2.min_hi, if2.min_lo, if2.sec_hi, if2.sec_lo}, if2.tick, if2.done, if2.running);
    endtask
    task automatic chk3();
        chk({if3.min_hi, if3.min_lo, if3.sec_hi, if3.sec_lo}, if3.tick, if3.done, if3.running);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pre1(input int m, input int s);
        {if1.pre_min_hi, if1.pre_min_lo, if1.pre_sec_hi, if1.pre_sec_lo} = mmss(m, s);
    endtask

    initial begin
        int m, s;
        rst_n = 1'b0;
        if1.enabled = 1'b0; if1.paused = 1'b0; if1.count_up = 1'b0;
        if2.enabled = 1'b0; if2.paused = 1'b0; if2.count_up = 1'b0;
        if3.enabled = 1'b0; if3.paused = 1'b0; if3.count_up = 1'b0;
        pre1(0, 3);
        {if2.pre_min_hi, if2.pre_min_lo, if2.pre_sec_hi, if2.pre_sec_lo} = mmss(0, 9);
        {if3.pre_min_hi, if3.pre_min_lo, if3.pre_sec_hi, if3.pre_sec_lo} = mmss(1, 0);
        #2;
        push("reset", 15'd0, 1'b0, 1'b0, 1'b0); chk1();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        push("idle_load", mmss(0, 3), 1'b0, 1'b0, 1'b0); chk1();
        push("idle_load3", mmss(1, 0), 1'b0, 1'b0, 1'b0); chk3();

        // CLK_DIV=1 count down to 00:00
        if1.enabled = 1'b1;
        cyc(); push("dn1", mmss(0, 2), 1'b1, 1'b0, 1'b1); chk1();
        cyc(); push("dn2", mmss(0, 1), 1'b1, 1'b0, 1'b1); chk1();
        cyc(); push("dn_term", RELOAD ? mmss(0, 3) : mmss(0, 0), 1'b1, 1'b1, RELOAD); chk1();
        cyc(); push("dn_after1", RELOAD ? mmss(0, 2) : mmss(0, 0), RELOAD, !RELOAD, RELOAD); chk1();
        cyc(); push("dn_after2", RELOAD ? mmss(0, 1) : mmss(0, 0), RELOAD, !RELOAD, RELOAD); chk1();
        if1.enabled = 1'b0;
        cyc(); push("disable", mmss(0, 3), 1'b0, 1'b0, 1'b0); chk1();

        // preset already at terminal when enabled rises
        pre1(0, 0);
        cyc(); push("idle_zero", mmss(0, 0), 1'b0, 1'b0, 1'b0); chk1();
        if1.enabled = 1'b1;
        cyc(); push("term_at_en", mmss(0, 0), 1'b0, 1'b1, RELOAD); chk1();
        if1.enabled = 1'b0;
        cyc();

        // clamping of out-of-range preset digits
        if1.pre_min_hi = 4'd0; if1.pre_min_lo = 4'd12; if1.pre_sec_hi = 3'd7; if1.pre_sec_lo = 4'd3;
        cyc(); push("clamp1", {4'd0, 4'd9, 3'd5, 4'd3}, 1'b0, 1'b0, 1'b0); chk1();
        if1.pre_min_hi = 4'd15; if1.pre_min_lo = 4'd10; if1.pre_sec_hi = 3'd6; if1.pre_sec_lo = 4'd15;
        cyc(); push("clamp2", mmss(99, 59), 1'b0, 1'b0, 1'b0); chk1();

        // direction change mid-run
        pre1(0, 5); if1.count_up = 1'b1;
        cyc();
        if1.enabled = 1'b1;
        cyc(); push("dir_up", mmss(0, 6), 1'b1, 1'b0, 1'b1); chk1();
        if1.count_up = 1'b0;
        cyc(); push("dir_dn1", mmss(0, 5), 1'b1, 1'b0, 1'b1); chk1();
        cyc(); push("dir_dn2", mmss(0, 4), 1'b1, 1'b0, 1'b1); chk1();
        if1.enabled = 1'b0;
        cyc();

        // count up to MAX_MIN:59 (MAX_MIN=1)
        pre1(0, 58); if1.count_up = 1'b1;
        cyc();
        if1.enabled = 1'b1;
        m = 0; s = 58;
        for (int i = 0; i < 60; i++) begin
            s++;
            if (s == 60) begin s = 0; m++; end
            push("up_step", mmss(m, s), 1'b1, 1'b0, 1'b1);
            cyc(); chk1();
        end
        cyc(); push("up_term", RELOAD ? mmss(0, 58) : mmss(1, 59), 1'b1, 1'b1, RELOAD); chk1();
        cyc(); push("up_after", RELOAD ? mmss(0, 59) : mmss(1, 59), RELOAD, !RELOAD, RELOAD); chk1();
        if1.enabled = 1'b0; if1.count_up = 1'b0;
        cyc();

        // CLK_DIV=3 first step latency and single-cycle tick
        if3.enabled = 1'b1;
        cyc(); push("div3_e0", mmss(1, 0), 1'b0, 1'b0, 1'b1); chk3();
        cyc(); push("div3_e1", mmss(1, 0), 1'b0, 1'b0, 1'b1); chk3();
        cyc(); push("div3_e2", mmss(0, 59), 1'b1, 1'b0, 1'b1); chk3();
        cyc(); push("div3_e3", mmss(0, 59), 1'b0, 1'b0, 1'b1); chk3();
        cyc(); push("div3_e4", mmss(0, 59), 1'b0, 1'b0, 1'b1); chk3();
        cyc(); push("div3_e5", mmss(0, 58), 1'b1, 1'b0, 1'b1); chk3();

        // CLK_DIV=2 pause holds digits and prescaler phase
        if2.enabled = 1'b1;
        cyc(); push("div2_e0", mmss(0, 9), 1'b0, 1'b0, 1'b1); chk2();
        cyc(); push("div2_e1", mmss(0, 8), 1'b1, 1'b0, 1'b1); chk2();
        cyc(); push("div2_e2", mmss(0, 8), 1'b0, 1'b0, 1'b1); chk2();
        if2.paused = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push("paused", mmss(0, 8), 1'b0, 1'b0, 1'b0);
            cyc(); chk2();
        end
        if2.paused = 1'b0;
        cyc(); push("resume1", mmss(0, 7), 1'b1, 1'b0, 1'b1); chk2();
        cyc(); push("resume2", mmss(0, 7), 1'b0, 1'b0, 1'b1); chk2();
        cyc(); push("resume3", mmss(0, 6), 1'b1, 1'b0, 1'b1); chk2();

        // asynchronous reset mid-run, then restart from preset
        pre1(0, 30);
        cyc();
        if1.enabled = 1'b1;
        cyc(); push("run30_1", mmss(0, 29), 1'b1, 1'b0, 1'b1); chk1();
        cyc(); push("run30_2", mmss(0, 28), 1'b1, 1'b0, 1'b1); chk1();
        #3 rst_n = 1'b0;
        #1 push("async_rst", 15'd0, 1'b0, 1'b0, 1'b0); chk1();
        #1 rst_n = 1'b1;
        cyc(); push("restart1", mmss(0, 29), 1'b1, 1'b0, 1'b1); chk1();
        cyc(); push("restart2", mmss(0, 28), 1'b1, 1'b0, 1'b1); chk1();

        if (sb.size() != 0) begin
            total++; bad++;
            $error("FAIL sb_leftover: got %0d queued want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised mm:ss BCD timer. It counts down or up from a BCD preset at a configurable clock-division rate, with pause and a terminal "done" indication. It replaces the fixed-function down-counter in the timer design and drives the 4-digit display path directly: min_hi, min_lo, sec_hi, sec_lo. The new block adds direction control, clamping of invalid presets, done/tick outputs and an optional auto-reload.

## Interface
- CLK_DIV, default 50_000_000: clk cycles per one-second tick, ≥1.
- MAX_MIN, default 99: terminal minute value when counting up, 0..99.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enabled  in  1  0: idle, digits track the preset; 1: run.
- paused  in  1  1: freeze prescaler and digits; ignored when enabled=0.
- count_up  in  1  1: count up from preset; 0: count down to 00:00.
- pre_min_hi  in  4  preset minutes tens, BCD.
- pre_min_lo  in  4  preset minutes units, BCD.
- pre_sec_hi  in  3  preset seconds tens, 0..5.
- pre_sec_lo  in  4  preset seconds units, BCD.
- min_hi, min_lo  out  4 each  current minutes, BCD.
- sec_hi  out  3  current seconds tens.
- sec_lo  out  4  current seconds units.
- tick  out  1  one-cycle pulse per digit update.
- done  out  1  terminal value reached.
- running  out  1  enabled & ~paused & ~done.

## Operation
- Reset (rst_n=0): all digits 0, prescaler 0, tick=0, done=0, running=0.
- Idle (enabled=0): every cycle, load the clamped preset into the digits.
  - Clamping: any BCD digit >9 becomes 9, and sec_hi >5 becomes 5.
  - In idle, prescaler=0, done=0 and tick=0.
- Run (enabled=1, paused=0, done=0): the prescaler counts 0..CLK_DIV-1 and then wraps to 0.
  - On the wrap edge, the digits step by one second and tick asserts for the following cycle.
- Down step: borrow chain sec_lo 9→0, sec_hi 5→0, min_lo 9→0, min_hi 9→0.
  - Reaching 00:00 sets done on the same edge.
- Up step: carry chain in the same radices.
  - Reaching MAX_MIN:59 sets done on the same edge.
- Preset already at terminal when enabled rises: done sets on the first clock edge with enabled=1. No tick is issued.
- Pause: prescaler and digits hold their values, and tick stays 0. Releasing pause resumes from the held prescaler value; no phase is lost.
- done is sticky: digits hold at the terminal value until enabled=0.
- count_up changes mid-run: the next step uses the new direction. done is evaluated against the terminal for the new direction.
- enabled falling mid-run: on the next edge, digits reload the preset and done clears.

## Timing
- First tick: CLK_DIV cycles after the first edge with enabled=1 and paused=0.
- Digits change on the prescaler wrap edge. tick is high during the cycle after that edge, aligned with the new digit values.
- CLK_DIV=1: one step per cycle; tick is continuously high while running.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- TIMER_RELOAD_EN defined: on reaching terminal, digits reload the clamped preset on the same edge.
  - done becomes a one-cycle pulse instead of a sticky level, and counting continues.
  - running ignores done.
- TIMER_RELOAD_EN undefined: sticky done and hold behaviour as described in Operation.

## Structure
- timer_pkg holds:
  - digit-width constants (4 bits for BCD digits, 3 bits for seconds tens);
  - radix constants (SEC_HI_MAX=5, BCD_MAX=9);
  - a clamp function for presets.
- Sub-module bcd_digit: a single mod-N up/down digit.
  - Inputs: step, dir, load, load_val.
  - Outputs: value, plus carry/borrow when stepping past N-1 or 0.
  - bcd_timer instantiates four of these in a ripple-enable chain.
  - The terminal compare and prescaler live in bcd_timer.

## Test plan
- CLK_DIV=1, preset 00:03, count_up=0, enabled rises → digits 00:02, 00:01, 00:00 on consecutive edges; done=1 on the third edge; digits then hold.
- CLK_DIV=3, preset 01:00 down → 00:59 appears exactly 3 cycles after enable; tick high for exactly one cycle.
- CLK_DIV=2, preset 00:09 down, paused=1 for 5 cycles mid-count → digits and prescaler frozen throughout; count resumes at the frozen phase after release.
- Preset min_lo=12, sec_hi=7 with enabled=0 → outputs read min_lo=9, sec_hi=5.
- MAX_MIN=1, CLK_DIV=1, preset 00:58 up → steps 00:59, 01:00 … 01:59, then done. Without TIMER_RELOAD_EN, done stays 1. With TIMER_RELOAD_EN, done pulses for one cycle and digits return to 00:58.
- rst_n asserted asynchronously mid-run → all outputs 0 immediately, without a clock edge. After release with enabled=1, counting restarts from the preset.
